// File: rtl/mem_burst_arbiter.sv
// mem_burst_arbiter
//   Shares one burst port (read and write) between CH_NUM requesters.
//   A round-robin scan picks one channel; its command is latched and drives
//   the burst port until the matching finish pulse. Strobes and finish pulses
//   are routed back to the granted channel only.
//
//   Optional build macro: MEM_ARB_FIXED_PRIO_EN
//     defined   -> fixed priority, lowest channel index always wins
//     undefined -> round-robin starting after the last granted channel
//
// Ports
//   mem_clk, rst_n            clock, asynchronous active-low reset
//   init_done                 memory calibration done; no grants while low
//   ch_rd_req / ch_wr_req     per-channel level requests, held until finish
//   ch_rd_len / ch_wr_len     flattened 10-bit burst lengths per channel
//   ch_rd_addr / ch_wr_addr   flattened start addresses per channel
//   ch_wr_data                flattened write data per channel
//   ch_wr_data_req            write-data strobe to the granted channel
//   ch_rd_data_valid          read-valid to the granted channel
//   ch_rd_data                read data, broadcast to all channels
//   ch_finish                 one-cycle completion pulse per channel
//   grant_id, busy            current/last grant, arbiter busy (grant..GAP)
//   rd_burst_* / wr_burst_*   burst port command, data and handshakes
module mem_burst_arbiter #(
    parameter int CH_NUM        = 2,
    parameter int ADDR_BITS     = 25,
    parameter int MEM_DATA_BITS = 32
) (
    input  logic                        mem_clk,
    input  logic                        rst_n,
    input  logic                        init_done,
    input  logic [CH_NUM-1:0]           ch_rd_req,
    input  logic [CH_NUM-1:0]           ch_wr_req,
    input  logic [CH_NUM*10-1:0]        ch_rd_len,
    input  logic [CH_NUM*10-1:0]        ch_wr_len,
    input  logic [CH_NUM*ADDR_BITS-1:0] ch_rd_addr,
    input  logic [CH_NUM*ADDR_BITS-1:0] ch_wr_addr,
    input  logic [CH_NUM*MEM_DATA_BITS-1:0] ch_wr_data,
    output logic [CH_NUM-1:0]           ch_wr_data_req,
    output logic [CH_NUM-1:0]           ch_rd_data_valid,
    output logic [MEM_DATA_BITS-1:0]    ch_rd_data,
    output logic [CH_NUM-1:0]           ch_finish,
    output logic [1:0]                  grant_id,
    output logic                        busy,
    output logic                        rd_burst_req,
    output logic                        wr_burst_req,
    output logic [9:0]                  rd_burst_len,
    output logic [9:0]                  wr_burst_len,
    output logic [ADDR_BITS-1:0]        rd_burst_addr,
    output logic [ADDR_BITS-1:0]        wr_burst_addr,
    output logic [MEM_DATA_BITS-1:0]    wr_burst_data,
    input  logic                        wr_burst_data_req,
    input  logic                        rd_burst_data_valid,
    input  logic                        rd_burst_finish,
    input  logic                        wr_burst_finish,
    input  logic [MEM_DATA_BITS-1:0]    rd_burst_data
);

    typedef enum logic [1:0] {IDLE, RD_BUSY, WR_BUSY, GAP} state_t;

    localparam logic [1:0] LAST_CH = 2'(CH_NUM - 1);

    state_t                   state_reg, state_next;
    logic [1:0]               rr_ptr_reg;
    logic [9:0]               len_reg;
    logic [ADDR_BITS-1:0]     addr_reg;

    // Per-channel views padded to 4 entries so a 2-bit index is always legal.
    logic [3:0]               rd_req_v, wr_req_v;
    logic [9:0]               rd_len_a  [4];
    logic [9:0]               wr_len_a  [4];
    logic [ADDR_BITS-1:0]     rd_addr_a [4];
    logic [ADDR_BITS-1:0]     wr_addr_a [4];
    logic [MEM_DATA_BITS-1:0] wr_data_a [4];

    logic       found, win_rd, finish_now;
    logic [1:0] win_ch;
    logic [2:0] scan_idx;
    logic       rd_active, wr_active, len_zero;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            if (gi < CH_NUM) begin : g_live
                assign rd_req_v[gi]  = ch_rd_req[gi];
                assign wr_req_v[gi]  = ch_wr_req[gi];
                assign rd_len_a[gi]  = ch_rd_len[10*gi +: 10];
                assign wr_len_a[gi]  = ch_wr_len[10*gi +: 10];
                assign rd_addr_a[gi] = ch_rd_addr[ADDR_BITS*gi +: ADDR_BITS];
                assign wr_addr_a[gi] = ch_wr_addr[ADDR_BITS*gi +: ADDR_BITS];
                assign wr_data_a[gi] = ch_wr_data[MEM_DATA_BITS*gi +: MEM_DATA_BITS];
            end else begin : g_pad
                assign rd_req_v[gi]  = 1'b0;
                assign wr_req_v[gi]  = 1'b0;
                assign rd_len_a[gi]  = '0;
                assign wr_len_a[gi]  = '0;
                assign rd_addr_a[gi] = '0;
                assign wr_addr_a[gi] = '0;
                assign wr_data_a[gi] = '0;
            end
        end
    endgenerate

    // Scan from the rr pointer, wrapping explicitly so non-power-of-2
    // channel counts never index a channel that does not exist.
    // In fixed-priority builds the pointer never leaves 0.
    always_comb begin
        found    = 1'b0;
        win_ch   = 2'd0;
        win_rd   = 1'b0;
        scan_idx = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (k < CH_NUM && !found) begin
                scan_idx = {1'b0, rr_ptr_reg} + 3'(k);
                if (scan_idx >= 3'(CH_NUM)) begin
                    scan_idx = scan_idx - 3'(CH_NUM);
                end
                if (rd_req_v[scan_idx[1:0]] || wr_req_v[scan_idx[1:0]]) begin
                    found  = 1'b1;
                    win_ch = scan_idx[1:0];
                    win_rd = rd_req_v[scan_idx[1:0]];  // read beats write
                end
            end
        end
    end

    assign rd_active = (state_reg == RD_BUSY);
    assign wr_active = (state_reg == WR_BUSY);
    assign len_zero  = (len_reg == 10'd0);

    // Losing init_done aborts the burst with no finish; a zero-length
    // command completes in its first busy cycle without touching the port.
    // Only the finish matching the current direction is honoured.
    always_comb begin
        state_next = state_reg;
        finish_now = 1'b0;
        case (state_reg)
            IDLE: begin
                if (init_done && found) begin
                    state_next = win_rd ? RD_BUSY : WR_BUSY;
                end
            end
            RD_BUSY: begin
                if (!init_done) begin
                    state_next = IDLE;
                end else if (len_zero || rd_burst_finish) begin
                    finish_now = 1'b1;
                    state_next = GAP;
                end
            end
            WR_BUSY: begin
                if (!init_done) begin
                    state_next = IDLE;
                end else if (len_zero || wr_burst_finish) begin
                    finish_now = 1'b1;
                    state_next = GAP;
                end
            end
            GAP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 2'd0;
            grant_id   <= 2'd0;
            len_reg    <= 10'd0;
            addr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && init_done && found) begin
                grant_id <= win_ch;
                len_reg  <= win_rd ? rd_len_a[win_ch]  : wr_len_a[win_ch];
                addr_reg <= win_rd ? rd_addr_a[win_ch] : wr_addr_a[win_ch];
            end
`ifndef MEM_ARB_FIXED_PRIO_EN
            // Aborted bursts never reach GAP, so the same channel goes first again.
            if (state_reg == GAP) begin
                rr_ptr_reg <= (grant_id == LAST_CH) ? 2'd0 : grant_id + 2'd1;
            end
`endif
        end
    end

    assign busy          = (state_reg != IDLE);
    assign rd_burst_req  = rd_active && !len_zero && init_done;
    assign wr_burst_req  = wr_active && !len_zero && init_done;
    assign rd_burst_len  = rd_active ? len_reg  : 10'd0;
    assign wr_burst_len  = wr_active ? len_reg  : 10'd0;
    assign rd_burst_addr = rd_active ? addr_reg : '0;
    assign wr_burst_addr = wr_active ? addr_reg : '0;
    assign wr_burst_data = wr_active ? wr_data_a[grant_id] : '0;
    assign ch_rd_data    = rd_active ? rd_burst_data : '0;

    generate
        for (gi = 0; gi < CH_NUM; gi++) begin : g_route
            assign ch_rd_data_valid[gi] = rd_active && (grant_id == 2'(gi)) && rd_burst_data_valid;
            assign ch_wr_data_req[gi]   = wr_active && (grant_id == 2'(gi)) && wr_burst_data_req;
            assign ch_finish[gi]        = finish_now && (grant_id == 2'(gi));
        end
    endgenerate

endmodule
